// File: rtl/stroke_cmd_fifo.sv
// ---------------------------------------------------------------------------
// stroke_cmd_fifo
//   Registered single-clock FIFO that holds stroke commands between the
//   host-command parser and the pen/stepper sequencer. The registered 'full'
//   flag drives the beeper stage directly. A sticky overflow flag records
//   any command dropped because it was written while the FIFO was full.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-high, overrides every input
//   wr_en     in   write request from parser
//   wr_data   in   command word to store
//   rd_en     in   read request from sequencer
//   rd_data   out  word popped by the previous accepted read (holds otherwise)
//   rd_valid  out  one-cycle pulse: rd_data holds a newly popped word
//   empty     out  occupancy == 0
//   full      out  occupancy == DEPTH
//   afull     out  occupancy >= AFULL_LVL
//   count     out  current occupancy, 0..DEPTH
//   overflow  out  sticky: a write was dropped because the FIFO was full
//   ovf_clr   in   clears overflow (a same-cycle new overflow wins)
// ---------------------------------------------------------------------------
module stroke_cmd_fifo #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic wr_acc;
    logic rd_acc;

    // Accept decisions use the registered flags, so a full FIFO rejects a
    // write even when a read frees a slot in the same cycle, and an empty
    // FIFO ignores a read even when a write arrives (no write-through).
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_acc;
        rd_data_d  = rd_data_q;

        // Pointers are ADDR_W bits wide and wrap DEPTH-1 -> 0 naturally.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            rd_data_d = mem[rd_ptr_q];
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CNT_W'(1);
        end

        // Flags are derived from the next count so they move with count.
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
        afull_d = (count_d >= AFULL_CNT);

        // A new overflow takes priority over a clear in the same cycle.
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable
    // because the pointers and count are reset, and leaving it out lets the
    // array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign afull    = afull_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stroke_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_stroke_cmd_fifo
//   Self-checking bench for stroke_cmd_fifo. A table of per-cycle vectors
//   with explicit expected flags covers fill, overflow and drain; hand-written
//   sequences cover wrap-around, simultaneous read/write and mid-run reset.
//   Written data is pushed to a scoreboard queue when an accepted write is
//   driven and popped when the DUT pulses rd_valid.
// ---------------------------------------------------------------------------
module tb_stroke_cmd_fifo;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              afull;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ovf_clr;

    stroke_cmd_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_LVL(AFULL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .empty   (empty),
        .full    (full),
        .afull   (afull),
        .count   (count),
        .overflow(overflow),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: occupancy, sticky overflow, and the scoreboard of
    // words expected to come out of the FIFO, oldest first.
    int                m_count = 0;
    logic              m_ovf   = 1'b0;
    logic [DATA_W-1:0] sb_q[$];

    typedef struct {
        logic              w;
        logic [DATA_W-1:0] d;
        logic              r;
        logic              c;
        int                exp_count;
        logic              exp_empty;
        logic              exp_full;
        logic              exp_afull;
        logic              exp_ovf;
        logic              exp_rv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict, advance past the edge, compare.
    task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        logic wa, ra, was_full;
        was_full = (m_count == DEPTH);
        wa = w && (m_count != DEPTH);
        ra = r && (m_count != 0);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        ovf_clr = c;
        if (wa) sb_q.push_back(d);
        @(posedge clk);
        #1;
        m_count = m_count + (wa ? 1 : 0) - (ra ? 1 : 0);
        if (w && was_full) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        check("count", 32'(count), 32'(m_count));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("afull", 32'(afull), 32'(m_count >= AFULL));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_valid", 32'(rd_valid), 32'(ra));
        if (ra && rd_valid) begin
            check("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
        end else if (ra) begin
            void'(sb_q.pop_front());
        end
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic add_vec(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c,
                           input int cnt, input logic ovf, input logic rv);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = c;
        v.exp_count = cnt;
        v.exp_empty = (cnt == 0);
        v.exp_full  = (cnt == DEPTH);
        v.exp_afull = (cnt >= AFULL);
        v.exp_ovf   = ovf;
        v.exp_rv    = rv;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;

        // Fill: 0x0001..0x0010, afull from count 14, full at 16.
        for (int i = 1; i <= DEPTH; i++) add_vec(1'b1, DATA_W'(i), 1'b0, 1'b0, i, 1'b0, 1'b0);
        // Write while full: dropped, overflow set; then clear it.
        add_vec(1'b1, 16'hBEEF, 1'b0, 1'b0, DEPTH, 1'b1, 1'b0);
        add_vec(1'b0, 16'h0000, 1'b0, 1'b1, DEPTH, 1'b0, 1'b0);
        // Drain with continuous reads, then one extra read on empty.
        for (int i = DEPTH - 1; i >= 0; i--) add_vec(1'b0, 16'h0000, 1'b1, 1'b0, i, 1'b0, 1'b1);
        add_vec(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Table-driven fill / overflow / drain.
        foreach (vecs[i]) begin
            cycle(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_afull", i), 32'(afull), 32'(vecs[i].exp_afull));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_rv", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
        end
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

        // Wrap-around: pointers cross DEPTH-1 -> 0 on the second pass.
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("wrap_count", 32'(count), 32'd0);

        // Empty with write and read: write only, no bypass.
        cycle(1'b1, 16'h3001, 1'b1, 1'b0);
        check("sim_empty_count", 32'(count), 32'd1);
        check("sim_empty_rv", 32'(rd_valid), 32'd0);

        // Mid-level with both: count unchanged, data order kept.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h3002 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'h3100, 1'b1, 1'b0);
        check("sim_mid_count", 32'(count), 32'd5);
        check("sim_mid_data", 32'(rd_data), 32'h3001);

        // Full with both: read accepted, write rejected, overflow set.
        for (int i = 0; i < 11; i++) cycle(1'b1, 16'h3200 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("sim_full_count", 32'(count), 32'd15);
        check("sim_full_ovf", 32'(overflow), 32'd1);

        // Clear attempted in the same cycle as a new overflow: set wins.
        cycle(1'b1, 16'h3300, 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Drain to 7 with overflow still set, then reset with traffic active.
        for (int i = 0; i < 9; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd7);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h4444;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_rv", 32'(rd_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);

        // Stored words are gone after reset: a new word is the first out.
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post_rst_data", 32'(rd_data), 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
